// File: rtl/timer_pkg.sv
// Shared types for the seconds-based interval timer.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} timer_state_t;
    typedef enum logic {ONE_SHOT, PERIODIC} mode_t;

endpackage

// File: rtl/sec_prescaler.sv
// Clock-cycle prescaler: tick is high on the enabled cycle where the count wraps
// from CLK_HZ-1 to 0.
module sec_prescaler #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] TC = W'(CLK_HZ - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (ena) begin
            if (cnt_q == TC) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/interval_timer.sv
// Interval timer: FSM, seconds down-counter and registered outputs around a
// one-second prescaler.
module interval_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int SEC_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_ena,
    input  logic             start,
    input  logic             pause,
    input  logic             cancel,
    input  logic             periodic,
    input  logic [SEC_W-1:0] interval_sec,
    output logic [SEC_W-1:0] remaining_sec,
    output logic             sec_tick,
    output logic             expired,
    output logic             running,
    output logic             done
);

    timer_state_t     state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [SEC_W-1:0] interval_q, interval_d;
    logic [SEC_W-1:0] remaining_q, remaining_d;
    logic             sec_tick_q, sec_tick_d;
    logic             expired_q, expired_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic cmd_start;
    logic presc_ena;
    logic presc_clr;
    logic pre_tick;
    logic last_sec;

    assign cmd_start = start && (interval_sec != '0);
    assign presc_ena = clk_ena && (state_q == RUN);
    assign presc_clr = cancel || cmd_start;
    // pre_tick is already suppressed by the prescaler whenever presc_clr is high
    assign last_sec  = pre_tick && (remaining_q == SEC_W'(1));

    sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .ena  (presc_ena),
        .clr  (presc_clr),
        .tick (pre_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= ONE_SHOT;
            interval_q  <= '0;
            remaining_q <= '0;
            sec_tick_q  <= 1'b0;
            expired_q   <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            interval_q  <= interval_d;
            remaining_q <= remaining_d;
            sec_tick_q  <= sec_tick_d;
            expired_q   <= expired_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = IDLE;
        end else if (cmd_start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (last_sec && (mode_q == ONE_SHOT)) state_d = DONE;
                    else if (pause)                       state_d = PAUSED;
                end
                PAUSED:  if (pause) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        mode_d      = mode_q;
        interval_d  = interval_q;
        remaining_d = remaining_q;
        sec_tick_d  = 1'b0;
        expired_d   = 1'b0;
        if (cancel) begin
            remaining_d = '0;
        end else if (cmd_start) begin
            remaining_d = interval_sec;
            interval_d  = interval_sec;
            mode_d      = periodic ? PERIODIC : ONE_SHOT;
        end else if (pre_tick) begin
            sec_tick_d = 1'b1;
            if (last_sec) begin
                expired_d   = 1'b1;
                remaining_d = (mode_q == PERIODIC) ? interval_q : '0;
            end else begin
                remaining_d = remaining_q - 1'b1;
            end
        end
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    assign remaining_sec = remaining_q;
    assign sec_tick      = sec_tick_q;
    assign expired       = expired_q;
    assign running       = running_q;
    assign done          = done_q;

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer at CLK_HZ=10, SEC_W=4: stimulus pushes
// expected tick/expiry events, a negedge monitor pops and compares them.
module tb_interval_timer;

    typedef struct {
        int   cyc;
        int   rem;
        logic exp;
        logic done;
        logic run;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       clk_ena;
    logic       start;
    logic       pause;
    logic       cancel;
    logic       periodic;
    logic [3:0] interval_sec;
    logic [3:0] remaining_sec;
    logic       sec_tick;
    logic       expired;
    logic       running;
    logic       done;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    interval_timer #(
        .CLK_HZ(10),
        .SEC_W (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_ena      (clk_ena),
        .start        (start),
        .pause        (pause),
        .cancel       (cancel),
        .periodic     (periodic),
        .interval_sec (interval_sec),
        .remaining_sec(remaining_sec),
        .sec_tick     (sec_tick),
        .expired      (expired),
        .running      (running),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input int r, input logic e, input logic d, input logic ru);
        ev_t ev;
        ev.cyc  = c;
        ev.rem  = r;
        ev.exp  = e;
        ev.done = d;
        ev.run  = ru;
        exp_q.push_back(ev);
    endtask

    always @(negedge clk) begin : monitor
        ev_t ev;
        if (!rst && (sec_tick || expired)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: sec_tick=%0d expired=%0d at cycle %0d, none expected",
                         sec_tick, expired, cyc);
            end else begin
                ev = exp_q.pop_front();
                check("ev_cycle", cyc, ev.cyc);
                check("ev_tick", int'(sec_tick), 1);
                check("ev_remaining", int'(remaining_sec), ev.rem);
                check("ev_expired", int'(expired), int'(ev.exp));
                check("ev_done", int'(done), int'(ev.done));
                check("ev_running", int'(running), int'(ev.run));
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_start(input int iv, input logic per, output int e0);
        interval_sec = 4'(iv);
        periodic     = per;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_remaining"}, int'(remaining_sec), 0);
        check({name, "_running"}, int'(running), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_tick"}, int'(sec_tick), 0);
        check({name, "_expired"}, int'(expired), 0);
    endtask

    initial begin
        int e0;
        int e1;
        rst          = 1'b1;
        clk_ena      = 1'b1;
        start        = 1'b0;
        pause        = 1'b0;
        cancel       = 1'b0;
        periodic     = 1'b0;
        interval_sec = '0;
        repeat (3) @(negedge clk);
        check_idle("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset_released");

        // one-shot 3 s
        do_start(3, 1'b0, e0);
        check("oneshot_load_rem", int'(remaining_sec), 3);
        check("oneshot_load_run", int'(running), 1);
        push(e0 + 10, 2, 1'b0, 1'b0, 1'b1);
        push(e0 + 20, 1, 1'b0, 1'b0, 1'b1);
        push(e0 + 30, 0, 1'b1, 1'b1, 1'b0);
        wait_until(e0 + 35);
        check("oneshot_done_hold", int'(done), 1);
        check("oneshot_rem_hold", int'(remaining_sec), 0);
        check("oneshot_queue", exp_q.size(), 0);

        // periodic 2 s
        do_start(2, 1'b1, e0);
        check("periodic_done_clr", int'(done), 0);
        for (int k = 1; k <= 6; k++)
            push(e0 + 10 * k, (k % 2 == 1) ? 1 : 2, (k % 2 == 0), 1'b0, 1'b1);
        wait_until(e0 + 65);
        check("periodic_reload_rem", int'(remaining_sec), 2);
        check("periodic_running", int'(running), 1);
        do_cancel();
        check_idle("cancel");
        wait_until(cyc + 15);
        check("periodic_queue", exp_q.size(), 0);

        // pause at edge 5, resume at edge 12 -> tick at 17
        do_start(1, 1'b0, e0);
        push(e0 + 17, 0, 1'b1, 1'b1, 1'b0);
        wait_until(e0 + 4);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("paused_running", int'(running), 0);
        check("paused_rem", int'(remaining_sec), 1);
        wait_until(e0 + 11);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("resumed_running", int'(running), 1);
        wait_until(e0 + 20);
        check("pause_queue", exp_q.size(), 0);

        // clk_ena low for 4 cycles -> tick at 14
        do_start(1, 1'b0, e0);
        push(e0 + 14, 0, 1'b1, 1'b1, 1'b0);
        wait_until(e0 + 2);
        clk_ena = 1'b0;
        repeat (2) @(negedge clk);
        check("ena_low_running", int'(running), 1);
        repeat (2) @(negedge clk);
        clk_ena = 1'b1;
        wait_until(e0 + 18);
        check("ena_queue", exp_q.size(), 0);

        // start with zero interval from IDLE is ignored
        do_cancel();
        do_start(0, 1'b0, e0);
        check_idle("zero_start");
        wait_until(e0 + 15);
        check("zero_running_later", int'(running), 0);

        // cancel and start in the same cycle
        do_start(3, 1'b0, e0);
        check("pre_collide_run", int'(running), 1);
        repeat (3) @(negedge clk);
        interval_sec = 4'd5;
        cancel       = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        start  = 1'b0;
        check("collide_running", int'(running), 0);
        check("collide_rem", int'(remaining_sec), 0);
        wait_until(cyc + 15);
        check("collide_queue", exp_q.size(), 0);

        // restart exactly on the expiry edge
        do_start(1, 1'b0, e0);
        wait_until(e0 + 9);
        do_start(2, 1'b0, e1);
        check("restart_rem", int'(remaining_sec), 2);
        check("restart_expired", int'(expired), 0);
        check("restart_tick", int'(sec_tick), 0);
        check("restart_running", int'(running), 1);
        check("restart_done", int'(done), 0);
        push(e1 + 10, 1, 1'b0, 1'b0, 1'b1);
        push(e1 + 20, 0, 1'b1, 1'b1, 1'b0);
        wait_until(e1 + 25);
        check("restart_queue", exp_q.size(), 0);

        // asynchronous reset mid-run
        do_start(5, 1'b0, e0);
        wait_until(e0 + 3);
        check("prereset_rem", int'(remaining_sec), 5);
        #2 rst = 1'b1;
        #1 check_idle("async_reset");
        @(negedge clk);
        rst = 1'b0;
        do_start(1, 1'b0, e0);
        push(e0 + 10, 0, 1'b1, 1'b1, 1'b0);
        wait_until(e0 + 15);
        check("post_reset_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
# interval_timer

Parametrised seconds-based interval timer for the puzzle alarm clock: a clock-cycle prescaler produces a one-second timebase, and a loadable down-counter measures a programmable interval in whole seconds. It supports one-shot and periodic modes, pause/resume and cancel. It exposes the remaining time for display and a single-cycle expiry pulse. It replaces fixed-interval counter chains such as snooze, puzzle time-limit and minute-tick generation.

## Interface
Parameters:
- CLK_HZ, 100_000_000, clock cycles per second; prescaler terminal count is CLK_HZ-1.
- SEC_W, 12, width of interval and remaining-time fields (max 4095 s).

Ports:
- clk, in, 1, system clock; single clock domain.
- rst, in, 1, reset; asynchronous, active-high.
- clk_ena, in, 1, global count enable; prescaler advances only when high.
- start, in, 1, pulse: load interval_sec and run.
- pause, in, 1, pulse: toggle RUN and PAUSED.
- cancel, in, 1, pulse: abort and return to IDLE.
- periodic, in, 1, mode sampled at start: 0 = one-shot, 1 = auto-reload.
- interval_sec, in, SEC_W, interval length in seconds, sampled at start.
- remaining_sec, out, SEC_W, seconds left in the current interval.
- sec_tick, out, 1, one-cycle pulse per elapsed second while running.
- expired, out, 1, one-cycle pulse when remaining reaches 0.
- running, out, 1, high in RUN.
- done, out, 1, level, high in DONE (one-shot finished).

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Command priority when several commands arrive in the same cycle: cancel > start > pause.
- Start:
  - Accepted in any state when interval_sec != 0.
  - Loads remaining_sec = interval_sec, latches interval and mode, clears the prescaler, enters RUN.
  - start with interval_sec == 0 is ignored; state and outputs are unchanged.
  - Restarting from RUN or PAUSED is legal and discards the old count.
- Cancel: any state -> IDLE, remaining_sec = 0, prescaler cleared, no expired pulse.
- Pause:
  - RUN -> PAUSED and PAUSED -> RUN.
  - In PAUSED the prescaler and remaining_sec are frozen.
  - Ignored in IDLE and DONE.
- Counting:
  - In RUN with clk_ena high, the prescaler increments.
  - At CLK_HZ-1 the prescaler wraps to 0 and remaining_sec decrements by 1.
  - clk_ena low freezes the prescaler without changing state.
- Expiry, when a decrement takes remaining_sec from 1 to 0:
  - expired pulses.
  - One-shot: -> DONE, remaining_sec holds 0.
  - Periodic: remaining_sec reloads the latched interval (never shows 0) and the block stays in RUN.
- DONE holds until start or cancel.
- Reset values: state IDLE, prescaler 0, remaining_sec 0, sec_tick 0, expired 0, running 0, done 0.

## Timing
- All outputs are registered.
- start sampled at edge E0: RUN and remaining_sec = interval_sec are visible in the cycle after E0.
- With clk_ena continuously high, the first sec_tick is high in the cycle after edge E0+CLK_HZ; each later tick follows CLK_HZ cycles after the previous one.
- expired is high in the same cycle as the final sec_tick of the interval.
- remaining_sec and state updates are visible in that same cycle.
- A pause held for N cycles delays all subsequent ticks by exactly N cycles; prescaler progress is preserved.
- start in the same cycle as a decrement or expiry wins: no expired pulse, and the new interval loads.
- rst asserted mid-count clears everything immediately, without waiting for a clock edge.

## Structure
- Package timer_pkg holds:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, PAUSED, DONE}.
  - typedef enum logic mode_t {ONE_SHOT, PERIODIC}.
- Sub-module sec_prescaler (parameter CLK_HZ):
  - Width $clog2(CLK_HZ).
  - Inputs clk, rst, ena, clr; output tick.
- The top level contains the FSM, the SEC_W down-counter and the output registers.

## Test plan
All scenarios use CLK_HZ=10, SEC_W=4 and clk_ena high unless stated.
- One-shot: start with interval=3, periodic=0 -> sec_tick at cycles 10, 20, 30 after start; expired at cycle 30; done high from 30; remaining_sec shows 3, 2, 1, 0.
- Periodic: interval=2, periodic=1 -> expired at cycles 20, 40, 60; remaining_sec sequence 2, 1, 2, 1, …; done never asserts.
- Pause and clk_ena gating:
  - Pause at cycle 5 for 7 cycles, then resume -> first tick moves to cycle 17.
  - clk_ena low for 4 cycles -> tick delayed by 4 cycles.
- Command collisions:
  - start with interval=0 -> stays in IDLE, all outputs 0.
  - cancel and start in the same cycle -> IDLE.
  - start on the expiry cycle -> no expired pulse, new interval loaded.
- Reset: assert rst asynchronously mid-RUN (remaining=5) -> all outputs 0 immediately.
  - After release, start with interval=1 -> expired at cycle 10.
